sdiv: RTL and testbench

- Sequential signed integer divider; the inverse operation of the team's registered 8x8 signed multiplier.
- Takes a 2N-bit signed dividend (a product-width value) and an N-bit signed divisor.
- Returns a 2N-bit quotient and an N-bit remainder after a fixed, data-independent latency.
- Used by the datapath wherever a scaled product must be divided back down; one radix-2 restoring step per cycle, with a start/busy/done handshake.

---
 rtl/sdiv_pkg.sv | 25 ++
 rtl/sdiv_step.sv | 35 +++
 rtl/sdiv.sv | 143 ++++++++++++++
 tb/tb_sdiv.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdiv_pkg.sv
// -----------------------------------------------------------------------------
// sdiv_pkg
// Shared arithmetic definitions for the signed multiply/divide datapath.
//   WD_DEF / WN_DEF : default operand widths (narrow N, wide 2N)
//   state_t         : divider FSM state encoding
//   abs_u           : two's-complement magnitude of a wide value, unsigned
// -----------------------------------------------------------------------------
package sdiv_pkg;

    localparam int WD_DEF = 8;
    localparam int WN_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Magnitude of a signed wide value. The most negative input maps to
    // 2^(WN_DEF-1), which is representable because the result is unsigned.
    function automatic logic [WN_DEF-1:0] abs_u(input logic [WN_DEF-1:0] v);
        return v[WN_DEF-1] ? -v : v;
    endfunction

endpackage

// File: rtl/sdiv_step.sv
// -----------------------------------------------------------------------------
// sdiv_step
// One combinational radix-2 restoring division step.
//   rem_in       : current partial remainder (always < divisor_mag)
//   dividend_bit : next dividend bit shifted into the remainder
//   divisor_mag  : unsigned divisor magnitude
//   rem_out      : next partial remainder
//   q_bit        : quotient bit produced by this step
// -----------------------------------------------------------------------------
module sdiv_step
    import sdiv_pkg::*;
#(
    parameter int WD = WD_DEF
) (
    input  logic [WD-1:0] rem_in,
    input  logic          dividend_bit,
    input  logic [WD-1:0] divisor_mag,
    output logic [WD-1:0] rem_out,
    output logic          q_bit
);

    // The shifted remainder needs one extra bit before the compare.
    logic [WD:0] shifted;
    logic [WD:0] diff;

    always_comb begin
        shifted = {rem_in, dividend_bit};
        diff    = shifted - {1'b0, divisor_mag};
        q_bit   = (shifted >= {1'b0, divisor_mag});
        // After a successful subtract the result is below divisor_mag, so
        // dropping the top bit loses nothing.
        rem_out = q_bit ? WD'(diff) : WD'(shifted);
    end

endmodule

// File: rtl/sdiv.sv
// -----------------------------------------------------------------------------
// sdiv
// Sequential signed divider, truncating toward zero (Verilog / and %).
// Fixed latency: done pulses WN+1 clocks after start is sampled.
//   clk       : system clock
//   areset    : asynchronous active-high reset
//   start     : request, sampled while idle
//   dividend  : WN-bit signed dividend, captured with start
//   divisor   : WD-bit signed divisor, captured with start
//   busy      : division in progress
//   done      : one-cycle result strobe
//   quotient  : WN-bit signed quotient (held until next result)
//   remainder : WD-bit signed remainder (held until next result)
//   dz        : last result was a divide by zero
//   ovf       : last result overflowed (-2^(WN-1) / -1)
// -----------------------------------------------------------------------------
module sdiv
    import sdiv_pkg::*;
#(
    parameter int WD = WD_DEF,
    parameter int WN = WN_DEF
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          start,
    input  logic [WN-1:0] dividend,
    input  logic [WD-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [WN-1:0] quotient,
    output logic [WD-1:0] remainder,
    output logic          dz,
    output logic          ovf
);

    localparam int CW = $clog2(WN);

    state_t        state, next_state;
    logic [CW-1:0] count;
    logic [WN-1:0] q_sh;      // dividend bits shift out as quotient bits shift in
    logic [WD-1:0] part_rem;
    logic [WD-1:0] div_mag;
    logic          sign_n, sign_d, zero_div;
    logic [WD-1:0] rem_next;
    logic          q_bit;
    logic          load, step, fix;
    logic          neg_q;

    sdiv_step #(.WD(WD)) u_step (
        .rem_in       (part_rem),
        .dividend_bit (q_sh[WN-1]),
        .divisor_mag  (div_mag),
        .rem_out      (rem_next),
        .q_bit        (q_bit)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        fix        = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                busy = 1'b1;
                if (count == CW'(WN - 1)) next_state = FIX;
            end
            FIX: begin
                fix        = 1'b1;
                busy       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign neg_q = sign_n ^ sign_d;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            count     <= '0;
            q_sh      <= '0;
            part_rem  <= '0;
            div_mag   <= '0;
            sign_n    <= 1'b0;
            sign_d    <= 1'b0;
            zero_div  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
            ovf       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= fix;
            if (load) begin
                q_sh     <= abs_u(dividend);
                div_mag  <= WD'(abs_u(WN_DEF'($signed(divisor))));
                sign_n   <= dividend[WN-1];
                sign_d   <= divisor[WD-1];
                zero_div <= (divisor == '0);
                part_rem <= '0;
                count    <= '0;
            end
            if (step) begin
                part_rem <= rem_next;
                q_sh     <= {q_sh[WN-2:0], q_bit};
                count    <= count + CW'(1);
            end
            if (fix) begin
                if (zero_div) begin
                    quotient  <= '0;
                    remainder <= '0;
                    dz        <= 1'b1;
                    ovf       <= 1'b0;
                end else begin
                    quotient  <= neg_q ? -q_sh : q_sh;
                    remainder <= sign_n ? -part_rem : part_rem;
                    dz        <= 1'b0;
                    // A positive quotient with its MSB set cannot be
                    // represented; only -2^(WN-1) / -1 reaches this.
                    ovf       <= ~neg_q & q_sh[WN-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_sdiv.sv
// -----------------------------------------------------------------------------
// tb_sdiv
// Scoreboard bench for sdiv: stimulus pushes expected results, a monitor
// pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_sdiv;
    import sdiv_pkg::*;

    localparam int WD  = WD_DEF;
    localparam int WN  = WN_DEF;
    localparam int LAT = WN + 1;

    logic          clk = 1'b0;
    logic          areset;
    logic          start;
    logic [WN-1:0] dividend;
    logic [WD-1:0] divisor;
    logic          busy, done, dz, ovf;
    logic [WN-1:0] quotient;
    logic [WD-1:0] remainder;

    sdiv #(.WD(WD), .WN(WN)) dut (
        .clk       (clk),
        .areset    (areset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            a;
        int            b;
        logic [WN-1:0] q;
        logic [WD-1:0] r;
        logic          dz;
        logic          ovf;
        int            start_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference: plain integer division, with the two special cases.
    function automatic exp_t model(input int a, input int b, input int sc);
        exp_t e;
        e.a = a; e.b = b; e.start_cyc = sc;
        e.dz = 1'b0; e.ovf = 1'b0;
        if (b == 0) begin
            e.q = '0; e.r = '0; e.dz = 1'b1;
        end else if (a == -32768 && b == -1) begin
            e.q = 16'h8000; e.r = '0; e.ovf = 1'b1;
        end else begin
            e.q = WN'(a / b);
            e.r = WD'(a % b);
        end
        return e;
    endfunction

    // Monitor: compare every presented result with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        int   recon;
        if (areset === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check($sformatf("quotient %0d/%0d", e.a, e.b), 32'(quotient), 32'(e.q));
                check($sformatf("remainder %0d/%0d", e.a, e.b), 32'(remainder), 32'(e.r));
                check($sformatf("dz %0d/%0d", e.a, e.b), 32'(dz), 32'(e.dz));
                check($sformatf("ovf %0d/%0d", e.a, e.b), 32'(ovf), 32'(e.ovf));
                check($sformatf("latency %0d/%0d", e.a, e.b), 32'(cyc - e.start_cyc), 32'(LAT));
                check($sformatf("busy_at_done %0d/%0d", e.a, e.b), 32'(busy), 32'd0);
                if (!e.dz && !e.ovf) begin
                    recon = int'($signed(quotient)) * e.b + int'($signed(remainder));
                    check($sformatf("invariant %0d/%0d", e.a, e.b), 32'(recon), 32'(e.a));
                end
            end
        end
    end

    // All tasks are entered and left at posedge + #1.
    task automatic wait_idle();
        int g = 0;
        while (busy !== 1'b0 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 100) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic issue(input int a, input int b);
        wait_idle();
        start    = 1'b1;
        dividend = WN'(a);
        divisor  = WD'(b);
        @(posedge clk); #1;
        start = 1'b0;
        sb.push_back(model(a, b, cyc));
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    int dir_a[7] = '{-100,  100, -100, -32768, 32767, 1234, -32768};
    int dir_b[7] = '{   7,   -7,   -7,   -128,   127,    0,     -1};

    initial begin
        areset   = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk); #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dz", 32'(dz), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        areset = 1'b0;
        @(posedge clk); #1;

        // Basic operation, busy held through the whole computation.
        issue(100, 7);
        for (int j = 0; j < LAT; j++) begin
            @(negedge clk);
            check($sformatf("busy_cycle_%0d", j), 32'(busy), 32'd1);
        end
        @(posedge clk); #1;

        // Sign matrix and edge cases.
        for (int i = 0; i < 7; i++) issue(dir_a[i], dir_b[i]);
        drain();

        // A second start while busy must be ignored.
        issue(500, 9);
        repeat (4) @(posedge clk); #1;
        start = 1'b1; dividend = WN'(-7); divisor = WD'(3);
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        repeat (3) @(posedge clk); #1;

        // start held high across done: second operation accepted in done cycle.
        wait_idle();
        start = 1'b1; dividend = WN'(-3000); divisor = WD'(41);
        @(posedge clk); #1;
        sb.push_back(model(-3000, 41, cyc));
        dividend = WN'(12345); divisor = WD'(-99);
        repeat (LAT + 1) @(posedge clk); #1;
        start = 1'b0;
        sb.push_back(model(12345, -99, cyc));
        drain();

        // Reset mid-division: immediate clear, no done afterwards.
        issue(20000, 3);
        repeat (8) @(posedge clk);
        #2 areset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_quotient", 32'(quotient), 32'd0);
        check("arst_remainder", 32'(remainder), 32'd0);
        check("arst_dz", 32'(dz), 32'd0);
        check("arst_ovf", 32'(ovf), 32'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        #2 areset = 1'b0;
        repeat (LAT + 3) @(posedge clk); #1;
        issue(-1000, 33);
        drain();

        // Random regression (divide-by-zero and overflow excluded).
        for (int n = 0; n < 2000; n++) begin
            logic [15:0] ra;
            logic [7:0]  rb;
            int a, b;
            ra = 16'($urandom);
            rb = 8'($urandom);
            if (n % 4 == 0) rb = 8'($urandom_range(0, 7)) - 8'd3;
            a = int'($signed(ra));
            b = int'($signed(rb));
            if (b == 0) b = 1;
            if (a == -32768 && b == -1) b = 1;
            issue(a, b);
        end
        drain();
        repeat (LAT + 2) @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
